onchip_mem_arbiter: RTL and testbench

- Shares one single-port on-chip RAM (32-bit, 1024 words, byte enables, 1-cycle read latency) between two Avalon-MM masters.
- m0 is the datapath; m1 is the debug/loader port.
- Round-robin arbitration, one access per cycle.
- Optional post-reset clear sequence zero-fills the RAM before either master is served.
- Sits between the masters and the RAM instance inside the system.

---
 rtl/onchip_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin front end for a single-port on-chip RAM with a 1-cycle read pipe.
// An optional zero-fill sequence runs after reset, and no master is served until it finishes.
module onchip_mem_arbiter #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 1024,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic                  busy,
  output logic                  dbg_state_o
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_ARB = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic                rdv0_q, rdv0_d;
  logic                rdv1_q, rdv1_d;
  logic                busy_q, busy_d;

  logic req0, req1, gnt0, gnt1, in_arb;

  // Avalon-MM handshake: a request is accepted in any cycle where read|write
  // is high and waitrequest is low; a stalled master holds its request.
  assign in_arb = (state_q == ST_ARB);
  assign req0   = m0_read | m0_write;
  assign req1   = m1_read | m1_write;
  assign gnt0   = in_arb & req0 & (~req1 | ~rr_ptr_q);
  assign gnt1   = in_arb & req1 & (~req0 |  rr_ptr_q);

  assign m0_waitrequest = ~in_arb | (req0 & ~gnt0);
  assign m1_waitrequest = ~in_arb | (req1 & ~gnt1);

  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    if (!in_arb) begin
      mem_address    = clr_addr_q;
      mem_byteenable = '1;
      mem_writedata  = '0;
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
    end else if (gnt1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
    end else if (gnt0) begin
      mem_chipselect = 1'b1;
      mem_write      = m0_write;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    busy_d     = busy_q;
    rr_ptr_d   = rr_ptr_q;
    // A read with write also high is a write, so it never returns data.
    rdv0_d     = gnt0 & m0_read & ~m0_write;
    rdv1_d     = gnt1 & m1_read & ~m1_write;
    if (!in_arb) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == LAST_ADDR) begin
        state_d = ST_ARB;
        busy_d  = 1'b0;
      end
    end else if (gnt0) begin
      rr_ptr_d = 1'b1;
    end else if (gnt1) begin
      rr_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_ARB;
      clr_addr_q <= '0;
      rr_ptr_q   <= 1'b0;
      rdv0_q     <= 1'b0;
      rdv1_q     <= 1'b0;
      busy_q     <= (CLEAR_ON_RESET != 0);
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      rr_ptr_q   <= rr_ptr_d;
      rdv0_q     <= rdv0_d;
      rdv1_q     <= rdv1_d;
      busy_q     <= busy_d;
    end
  end

  assign m0_readdatavalid = rdv0_q;
  assign m1_readdatavalid = rdv1_q;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign busy             = busy_q;
  assign dbg_state_o      = (state_q == ST_ARB);

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural 1-cycle-latency RAM behind it.
module tb_onchip_mem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect, mem_write;
  logic [DATA_W-1:0] mem_writedata, mem_readdata;
  logic              busy, dbg_state_o;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] ram [0:1023];

  // clock / reset block
  always #5 clk = ~clk;

  onchip_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(1024), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .busy(busy), .dbg_state_o(dbg_state_o)
  );

  // Behavioural single-port RAM, registered read.
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BE_W; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
    m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic drive_m1(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
    m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  task automatic idle();
    drive_m0(1'b0, 1'b0, '0, '0, '0);
    drive_m1(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_reset();
    int cnt;
    int bad;
    reset = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", busy); end
    checks++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL reset_rdv got %b%b exp 00", m0_readdatavalid, m1_readdatavalid);
    end
    checks++;
    if (dbg_state_o !== 1'b0) begin errors++; $display("FAIL reset_state got %b exp 0", dbg_state_o); end
    reset = 1'b0;
    #1;
    cnt = 0;
    bad = 0;
    while (busy === 1'b1 && cnt < 2000) begin
      if (!(m0_waitrequest && m1_waitrequest && mem_chipselect && mem_write)) bad++;
      cnt++;
      tick();
    end
    checks++;
    if (cnt != 1024) begin errors++; $display("FAIL clear_len got %0d exp 1024", cnt); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL clear_wait got %0d bad cycles exp 0", bad); end
    checks++;
    if (dbg_state_o !== 1'b1) begin errors++; $display("FAIL clear_done_state got %b exp 1", dbg_state_o); end
  endtask

  task automatic test_clear_read();
    drive_m0(1'b1, 1'b0, 10'h3FF, 4'hF, '0);
    #1;
    checks++;
    if (m0_waitrequest !== 1'b0 || mem_chipselect !== 1'b1 || mem_write !== 1'b0 || mem_address !== 10'h3FF) begin
      errors++; $display("FAIL clear_read_issue got wr=%b cs=%b we=%b a=%h exp 0 1 0 3ff",
                         m0_waitrequest, mem_chipselect, mem_write, mem_address);
    end
    tick();
    idle();
    #1;
    checks++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h0 || m1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL clear_read_data got v=%b d=%h v1=%b exp 1 00000000 0",
                         m0_readdatavalid, m0_readdata, m1_readdatavalid);
    end
  endtask

  task automatic test_write_read();
    drive_m0(1'b0, 1'b1, 10'h005, 4'hF, 32'hDEADBEEF);
    #1;
    checks++;
    if (m0_waitrequest !== 1'b0 || mem_write !== 1'b1 || mem_writedata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_issue got wr=%b we=%b d=%h exp 0 1 deadbeef",
                         m0_waitrequest, mem_write, mem_writedata);
    end
    tick();
    drive_m0(1'b1, 1'b0, 10'h005, 4'hF, '0);
    #1;
    checks++;
    if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL wr_no_rdv got %b exp 0", m0_readdatavalid); end
    tick();
    idle();
    #1;
    checks++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hDEADBEEF || m1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL wr_rd_data got v=%b d=%h v1=%b exp 1 deadbeef 0",
                         m0_readdatavalid, m0_readdata, m1_readdatavalid);
    end
  endtask

  task automatic test_round_robin();
    logic m0_win;
    drive_m0(1'b0, 1'b1, 10'h010, 4'hF, 32'h10101010);
    tick();
    idle();
    drive_m1(1'b0, 1'b1, 10'h020, 4'hF, 32'h20202020);
    tick();
    drive_m0(1'b1, 1'b0, 10'h010, 4'hF, '0);
    drive_m1(1'b1, 1'b0, 10'h020, 4'hF, '0);
    for (int k = 0; k < 6; k++) begin
      #1;
      m0_win = (k % 2 == 0);
      checks++;
      if (m0_waitrequest !== !m0_win || m1_waitrequest !== m0_win ||
          mem_address !== (m0_win ? 10'h010 : 10'h020)) begin
        errors++; $display("FAIL rr_grant k=%0d got w0=%b w1=%b a=%h exp w0=%b", k,
                           m0_waitrequest, m1_waitrequest, mem_address, !m0_win);
      end
      if (k > 0) begin
        checks++;
        if (m0_readdatavalid !== !m0_win || m1_readdatavalid !== m0_win ||
            (!m0_win && m0_readdata !== 32'h10101010) || (m0_win && m1_readdata !== 32'h20202020)) begin
          errors++; $display("FAIL rr_return k=%0d got v0=%b v1=%b d=%h", k,
                             m0_readdatavalid, m1_readdatavalid, mem_readdata);
        end
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if (m1_readdatavalid !== 1'b1 || m0_readdatavalid !== 1'b0 || m1_readdata !== 32'h20202020) begin
      errors++; $display("FAIL rr_last got v0=%b v1=%b d=%h exp 0 1 20202020",
                         m0_readdatavalid, m1_readdatavalid, m1_readdata);
    end
  endtask

  task automatic test_byteenable();
    drive_m1(1'b0, 1'b1, 10'h007, 4'hF, 32'hFFFFFFFF);
    tick();
    drive_m1(1'b0, 1'b1, 10'h007, 4'h3, 32'h11223344);
    tick();
    drive_m1(1'b1, 1'b0, 10'h007, 4'hF, '0);
    tick();
    idle();
    #1;
    checks++;
    if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'hFFFF3344 || m0_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL be_merge got v1=%b d=%h v0=%b exp 1 ffff3344 0",
                         m1_readdatavalid, m1_readdata, m0_readdatavalid);
    end
  endtask

  task automatic test_read_write_both();
    drive_m0(1'b1, 1'b1, 10'h008, 4'hF, 32'hA5A5A5A5);
    #1;
    checks++;
    if (m0_waitrequest !== 1'b0 || mem_write !== 1'b1) begin
      errors++; $display("FAIL rw_issue got wr=%b we=%b exp 0 1", m0_waitrequest, mem_write);
    end
    tick();
    idle();
    #1;
    checks++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL rw_no_rdv got %b%b exp 00", m0_readdatavalid, m1_readdatavalid);
    end
    drive_m0(1'b1, 1'b0, 10'h008, 4'hF, '0);
    tick();
    idle();
    #1;
    checks++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL rw_readback got v=%b d=%h exp 1 a5a5a5a5", m0_readdatavalid, m0_readdata);
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    drive_m0(1'b1, 1'b0, 10'h005, 4'hF, '0);
    reset = 1'b1;
    #1;
    checks++;
    if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL rst_mid_grant got %b exp 0", m0_waitrequest); end
    tick();
    idle();
    #1;
    checks++;
    if (m0_readdatavalid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL rst_mid_rdv got v=%b busy=%b exp 0 1", m0_readdatavalid, busy);
    end
    tick();
    reset = 1'b0;
    #1;
    cnt = 0;
    while (busy === 1'b1 && cnt < 2000) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt != 1024) begin errors++; $display("FAIL rst_mid_clear_len got %0d exp 1024", cnt); end
    drive_m0(1'b1, 1'b0, 10'h005, 4'hF, '0);
    drive_m1(1'b1, 1'b0, 10'h020, 4'hF, '0);
    #1;
    checks++;
    if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
      errors++; $display("FAIL rst_rr_first got w0=%b w1=%b exp 0 1", m0_waitrequest, m1_waitrequest);
    end
    tick();
    checks++;
    if (m1_waitrequest !== 1'b0 || m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h0) begin
      errors++; $display("FAIL rst_rr_second got w1=%b v0=%b d=%h exp 0 1 00000000",
                         m1_waitrequest, m0_readdatavalid, m0_readdata);
    end
    tick();
    idle();
    #1;
    checks++;
    if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h0) begin
      errors++; $display("FAIL rst_rr_m1_data got v1=%b d=%h exp 1 00000000", m1_readdatavalid, m1_readdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'hC0DE0000 | i;
    test_reset();
    test_clear_read();
    test_write_read();
    test_round_robin();
    test_byteenable();
    test_read_write_both();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
